// File: rtl/groovy_pkg.sv
// Shared definitions for the HPS command scheduler: engine job kinds,
// scheduler FSM states, sound channel codes and the audio length helper.
package groovy_pkg;

    // Job kind as presented to the DDR fetch engine on eng_kind
    typedef enum logic [1:0] {
        KIND_SWR  = 2'd0,
        KIND_AUD  = 2'd1,
        KIND_LZ4  = 2'd2,
        KIND_BLIT = 2'd3
    } eng_kind_t;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_HOLD  = 3'd4
    } sched_state_t;

    // sound_chan codes shared with hps_ext; code 3 behaves as stereo
    localparam logic [1:0] SND_OFF    = 2'd0;
    localparam logic [1:0] SND_MONO   = 2'd1;
    localparam logic [1:0] SND_STEREO = 2'd2;

    // Number of consecutive grants blit may lose to lz4 before it wins
    localparam logic [2:0] STARVE_LIMIT = 3'd4;

    // Audio job byte length: 2 bytes per frame mono, 4 bytes per frame stereo
    function automatic logic [31:0] audioLen(input logic [15:0] samples,
                                             input logic [1:0]  chan);
        logic [31:0] len;
        case (chan)
            SND_OFF:  len = 32'd0;
            SND_MONO: len = {15'd0, samples, 1'b0};
            default:  len = {14'd0, samples, 2'b0};
        endcase
        return len;
    endfunction

endpackage

// File: rtl/groovy_watchdog.sv
// Loadable down-counter that flags a job which has run too long.
// The expire strobe is high while enabled and the count has reached zero.
module groovy_watchdog #(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_enable,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    // Load on job issue, then count down once per enabled cycle, stopping at zero
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expire = i_enable && (r_count == '0);

endmodule

// File: rtl/groovy_cmd_sched.sv
// Command scheduler: arbitrates the HPS command flags onto the single DDR
// fetch engine, runs one job at a time under a watchdog and acknowledges
// each command back to hps_ext with a one-cycle reset pulse.
module groovy_cmd_sched
    import groovy_pkg::*;
#(
    parameter logic [31:0] SWR_BASE  = 32'h0000_0000,
    parameter logic [31:0] SWR_BYTES = 32'd64,
    parameter logic [31:0] AUD_BASE  = 32'h0010_0000,
    parameter logic [31:0] BLIT_BASE = 32'h0020_0000,
    parameter logic [31:0] LZ4A_BASE = 32'h0040_0000,
    parameter logic [31:0] LZ4B_BASE = 32'h0060_0000,
    parameter logic [23:0] TIMEOUT   = 24'd2_000_000
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_cmd_switchres,
    input  logic        i_cmd_audio,
    input  logic        i_cmd_blit_lz4,
    input  logic        i_cmd_blit,
    input  logic [15:0] i_audio_samples,
    input  logic [1:0]  i_sound_chan,
    input  logic        i_lz4_AB,
    input  logic [31:0] i_lz4_size,
    input  logic [31:0] i_blit_bytes,
    output logic        o_eng_start,
    output logic [1:0]  o_eng_kind,
    output logic [31:0] o_eng_addr,
    output logic [31:0] o_eng_len,
    input  logic        i_eng_busy,
    input  logic        i_eng_done,
    output logic        o_reset_switchres,
    output logic        o_reset_audio,
    output logic        o_reset_blit_lz4,
    output logic        o_reset_blit,
    output logic        o_sched_busy,
    output logic        o_err_timeout
);

    sched_state_t r_state;
    sched_state_t w_nextState;

    eng_kind_t    r_kind;
    logic [31:0]  r_engAddr;
    logic [31:0]  r_engLen;
    logic         r_engStart;
    logic         r_errTimeout;
    logic [2:0]   r_blitLoss;

    eng_kind_t    w_grantKind;
    logic         w_grantValid;
    logic [31:0]  w_grantAddr;
    logic [31:0]  w_grantLen;
    logic         w_blitWins;
    logic         w_anyCmd;

    logic         w_wdLoad;
    logic         w_wdEnable;
    logic         w_wdExpire;

    // Watchdog armed when the job is issued and running only while waiting on the engine
    assign w_wdLoad   = (r_state == ST_ISSUE);
    assign w_wdEnable = (r_state == ST_WAIT);

    groovy_watchdog #(
        .WIDTH (24)
    ) uWatchdog (
        .i_clk       (i_clk_sys),
        .i_reset     (i_reset),
        .i_load      (w_wdLoad),
        .i_loadValue (TIMEOUT),
        .i_enable    (w_wdEnable),
        .o_expire    (w_wdExpire)
    );

    // Fixed-priority arbiter with the blit starvation override and job parameter selection
    always_comb begin
        w_grantKind  = KIND_SWR;
        w_grantAddr  = 32'd0;
        w_grantLen   = 32'd0;
        w_anyCmd     = i_cmd_switchres | i_cmd_audio | i_cmd_blit_lz4 | i_cmd_blit;
        w_blitWins   = i_cmd_blit && (!i_cmd_blit_lz4 || (r_blitLoss >= STARVE_LIMIT));
        w_grantValid = w_anyCmd && !i_eng_busy;

        if (i_cmd_switchres) begin
            w_grantKind = KIND_SWR;
            w_grantAddr = SWR_BASE;
            w_grantLen  = SWR_BYTES;
        end else if (i_cmd_audio) begin
            w_grantKind = KIND_AUD;
            w_grantAddr = AUD_BASE;
            w_grantLen  = audioLen(i_audio_samples, i_sound_chan);
        end else if (w_blitWins) begin
            w_grantKind = KIND_BLIT;
            w_grantAddr = BLIT_BASE;
            w_grantLen  = i_blit_bytes;
        end else if (i_cmd_blit_lz4) begin
            w_grantKind = KIND_LZ4;
            w_grantAddr = i_lz4_AB ? LZ4B_BASE : LZ4A_BASE;
            w_grantLen  = i_lz4_size;
        end
    end

    // Next-state logic; zero-length jobs skip the engine and go straight to the ack
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grantValid) begin
                    w_nextState = (w_grantLen == 32'd0) ? ST_ACK : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_eng_done || w_wdExpire) begin
                    w_nextState = ST_ACK;
                end
            end
            ST_ACK: begin
                w_nextState = ST_HOLD;
            end
            ST_HOLD: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Job latch, start strobe, starvation counter and sticky timeout flag
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_kind       <= KIND_SWR;
            r_engAddr    <= 32'd0;
            r_engLen     <= 32'd0;
            r_engStart   <= 1'b0;
            r_errTimeout <= 1'b0;
            r_blitLoss   <= 3'd0;
        end else begin
            r_engStart <= (r_state == ST_ISSUE);

            if ((r_state == ST_IDLE) && w_grantValid) begin
                r_kind    <= w_grantKind;
                r_engAddr <= w_grantAddr;
                r_engLen  <= w_grantLen;
                if (w_grantKind == KIND_BLIT) begin
                    r_blitLoss <= 3'd0;
                end else if ((w_grantKind == KIND_LZ4) && i_cmd_blit &&
                             (r_blitLoss < STARVE_LIMIT)) begin
                    r_blitLoss <= r_blitLoss + 3'd1;
                end
            end

            if ((r_state == ST_WAIT) && w_wdExpire && !i_eng_done) begin
                r_errTimeout <= 1'b1;
            end
        end
    end

    assign o_eng_start       = r_engStart;
    assign o_eng_kind        = r_kind;
    assign o_eng_addr        = r_engAddr;
    assign o_eng_len         = r_engLen;
    assign o_reset_switchres = (r_state == ST_ACK) && (r_kind == KIND_SWR);
    assign o_reset_audio     = (r_state == ST_ACK) && (r_kind == KIND_AUD);
    assign o_reset_blit_lz4  = (r_state == ST_ACK) && (r_kind == KIND_LZ4);
    assign o_reset_blit      = (r_state == ST_ACK) && (r_kind == KIND_BLIT);
    assign o_sched_busy      = (r_state != ST_IDLE);
    assign o_err_timeout     = r_errTimeout;

endmodule

// File: tb/tb_groovy_cmd_sched.sv
// Directed testbench for groovy_cmd_sched with a scoreboard of expected engine jobs.
module tb_groovy_cmd_sched;

    localparam logic [31:0] SWR_BASE   = 32'h0000_0000;
    localparam logic [31:0] SWR_BYTES  = 32'd64;
    localparam logic [31:0] AUD_BASE   = 32'h0010_0000;
    localparam logic [31:0] BLIT_BASE  = 32'h0020_0000;
    localparam logic [31:0] LZ4A_BASE  = 32'h0040_0000;
    localparam logic [31:0] LZ4B_BASE  = 32'h0060_0000;
    localparam int          TB_TIMEOUT = 100;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] len;
    } job_t;

    logic        clk_sys = 1'b0;
    logic        i_reset;
    logic        i_cmd_switchres, i_cmd_audio, i_cmd_blit_lz4, i_cmd_blit;
    logic [15:0] i_audio_samples;
    logic [1:0]  i_sound_chan;
    logic        i_lz4_AB;
    logic [31:0] i_lz4_size, i_blit_bytes;
    logic        o_eng_start;
    logic [1:0]  o_eng_kind;
    logic [31:0] o_eng_addr, o_eng_len;
    logic        i_eng_busy, i_eng_done;
    logic        o_reset_switchres, o_reset_audio, o_reset_blit_lz4, o_reset_blit;
    logic        o_sched_busy, o_err_timeout;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    job_t expQ[$];

    groovy_cmd_sched #(
        .TIMEOUT (24'd100)
    ) dut (
        .i_clk_sys         (clk_sys),
        .i_reset           (i_reset),
        .i_cmd_switchres   (i_cmd_switchres),
        .i_cmd_audio       (i_cmd_audio),
        .i_cmd_blit_lz4    (i_cmd_blit_lz4),
        .i_cmd_blit        (i_cmd_blit),
        .i_audio_samples   (i_audio_samples),
        .i_sound_chan      (i_sound_chan),
        .i_lz4_AB          (i_lz4_AB),
        .i_lz4_size        (i_lz4_size),
        .i_blit_bytes      (i_blit_bytes),
        .o_eng_start       (o_eng_start),
        .o_eng_kind        (o_eng_kind),
        .o_eng_addr        (o_eng_addr),
        .o_eng_len         (o_eng_len),
        .i_eng_busy        (i_eng_busy),
        .i_eng_done        (i_eng_done),
        .o_reset_switchres (o_reset_switchres),
        .o_reset_audio     (o_reset_audio),
        .o_reset_blit_lz4  (o_reset_blit_lz4),
        .o_reset_blit      (o_reset_blit),
        .o_sched_busy      (o_sched_busy),
        .o_err_timeout     (o_err_timeout)
    );

    // 100 MHz system clock
    always #5 clk_sys = ~clk_sys;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk_sys);
        cyc++;
        #1;
    endtask

    // Return to IDLE after an ACK cycle (ACK -> HOLD -> IDLE)
    task automatic settle();
        tick();
        tick();
    endtask

    // One counted comparison
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ackVec();
        return {o_reset_blit, o_reset_blit_lz4, o_reset_audio, o_reset_switchres};
    endfunction

    task automatic pushJob(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] len);
        job_t j;
        j.kind = kind;
        j.addr = addr;
        j.len  = len;
        expQ.push_back(j);
    endtask

    task automatic applyStimulus(input logic [1:0] kind, input logic value);
        case (kind)
            2'd0:    i_cmd_switchres = value;
            2'd1:    i_cmd_audio     = value;
            2'd2:    i_cmd_blit_lz4  = value;
            default: i_cmd_blit      = value;
        endcase
    endtask

    // Wait (bounded) for eng_start and compare the job against the scoreboard
    task automatic waitStart(input string tag, output int sc, output bit ok);
        job_t e;
        ok = 1'b0;
        sc = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (o_eng_start === 1'b1) begin
                ok = 1'b1;
                sc = cyc;
            end
        end
        checkOutput({tag, " start seen"}, 32'(ok), 32'd1);
        if (ok) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL %s scoreboard: observed unexpected job expected none", tag);
            end else begin
                e = expQ.pop_front();
                checkOutput({tag, " kind"}, 32'(o_eng_kind), 32'(e.kind));
                checkOutput({tag, " addr"}, o_eng_addr, e.addr);
                checkOutput({tag, " len"},  o_eng_len,  e.len);
            end
        end
    endtask

    // Complete the job: done pulse after doneDelay cycles, or let the watchdog fire when doneDelay < 0
    task automatic finishJob(input string tag, input int sc, input int doneDelay,
                             input logic [1:0] kind, input bit clearFlag, input logic expErr);
        logic [3:0] expV;
        bit         gotAck;
        int         ackCyc;
        expV   = 4'b0001 << kind;
        gotAck = 1'b0;
        ackCyc = -1;
        tick();
        checkOutput({tag, " start one cycle"}, 32'(o_eng_start), 32'd0);
        if (doneDelay > 0) begin
            while (cyc < sc + doneDelay) tick();
            i_eng_done = 1'b1;
            tick();
            i_eng_done = 1'b0;
            checkOutput({tag, " ack"}, 32'(ackVec()), 32'(expV));
        end else begin
            for (int i = 0; i < TB_TIMEOUT + 20 && !gotAck; i++) begin
                if (ackVec() != 4'd0) begin
                    gotAck = 1'b1;
                    ackCyc = cyc;
                end else begin
                    tick();
                end
            end
            checkOutput({tag, " timeout ack seen"}, 32'(gotAck), 32'd1);
            checkOutput({tag, " timeout ack cycle"}, 32'(ackCyc - sc), 32'(TB_TIMEOUT + 1));
            checkOutput({tag, " ack"}, 32'(ackVec()), 32'(expV));
        end
        checkOutput({tag, " err_timeout"}, 32'(o_err_timeout), 32'(expErr));
        if (clearFlag) applyStimulus(kind, 1'b0);
    endtask

    task automatic runJob(input string tag, input logic [1:0] kind, input int doneDelay,
                          input logic expErr, input bit clearFlag, output int sc);
        bit ok;
        waitStart(tag, sc, ok);
        if (ok) finishJob(tag, sc, doneDelay, kind, clearFlag, expErr);
        else if (clearFlag) applyStimulus(kind, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " eng_start"}, 32'(o_eng_start), 32'd0);
        checkOutput({tag, " eng_kind"},  32'(o_eng_kind),  32'd0);
        checkOutput({tag, " eng_addr"},  o_eng_addr,       32'd0);
        checkOutput({tag, " eng_len"},   o_eng_len,        32'd0);
        checkOutput({tag, " sched_busy"}, 32'(o_sched_busy), 32'd0);
        checkOutput({tag, " acks"},      32'(ackVec()),    32'd0);
        checkOutput({tag, " err"},       32'(o_err_timeout), 32'd0);
    endtask

    initial begin
        int  c0, sc, rc, ackCyc;
        bit  ok, sawStart;

        i_reset = 1'b1;
        i_cmd_switchres = 1'b0; i_cmd_audio = 1'b0; i_cmd_blit_lz4 = 1'b0; i_cmd_blit = 1'b0;
        i_audio_samples = 16'd0; i_sound_chan = 2'd0; i_lz4_AB = 1'b0;
        i_lz4_size = 32'd0; i_blit_bytes = 32'd0; i_eng_busy = 1'b0; i_eng_done = 1'b0;

        // Reset values
        repeat (3) tick();
        checkAllZero("reset");
        i_reset = 1'b0;
        tick();

        // Raw blit latency and ack timing
        i_blit_bytes = 32'd921600;
        pushJob(2'd3, BLIT_BASE, 32'd921600);
        c0 = cyc;
        applyStimulus(2'd3, 1'b1);
        runJob("t1 blit", 2'd3, 48, 1'b0, 1'b1, sc);
        checkOutput("t1 start latency", 32'(sc - c0), 32'd2);
        checkOutput("t1 ack cycle", 32'(cyc - c0), 32'd51);
        tick();
        checkOutput("t1 busy in hold", 32'(o_sched_busy), 32'd1);
        tick();
        checkOutput("t1 idle at +53", 32'(o_sched_busy), 32'd0);

        // Simultaneous commands: priority order swr, aud, lz4
        i_lz4_AB = 1'b1; i_lz4_size = 32'd5000; i_sound_chan = 2'd2; i_audio_samples = 16'd800;
        pushJob(2'd0, SWR_BASE, SWR_BYTES);
        pushJob(2'd1, AUD_BASE, 32'd3200);
        pushJob(2'd2, LZ4B_BASE, 32'd5000);
        applyStimulus(2'd0, 1'b1); applyStimulus(2'd1, 1'b1); applyStimulus(2'd2, 1'b1);
        runJob("t2 swr", 2'd0, 5, 1'b0, 1'b1, sc);
        runJob("t2 aud", 2'd1, 5, 1'b0, 1'b1, sc);
        runJob("t2 lz4", 2'd2, 5, 1'b0, 1'b1, sc);
        settle();

        // Audio mono length, then zero-length audio
        i_sound_chan = 2'd1;
        pushJob(2'd1, AUD_BASE, 32'd1600);
        applyStimulus(2'd1, 1'b1);
        runJob("t3 mono", 2'd1, 3, 1'b0, 1'b1, sc);
        settle();
        i_sound_chan = 2'd0;
        c0 = cyc;
        applyStimulus(2'd1, 1'b1);
        sawStart = 1'b0; ok = 1'b0; ackCyc = -1;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (o_eng_start) sawStart = 1'b1;
            if (ackVec() != 4'd0) begin
                ok = 1'b1;
                ackCyc = cyc;
            end
        end
        checkOutput("t3 off no start", 32'(sawStart), 32'd0);
        checkOutput("t3 off ack seen", 32'(ok), 32'd1);
        checkOutput("t3 off ack cycle", 32'(ackCyc - c0), 32'd1);
        checkOutput("t3 off ack kind", 32'(ackVec()), 32'd2);
        applyStimulus(2'd1, 1'b0);
        settle();

        // eng_busy holds off the grant
        i_eng_busy = 1'b1;
        pushJob(2'd0, SWR_BASE, SWR_BYTES);
        applyStimulus(2'd0, 1'b1);
        repeat (6) tick();
        checkOutput("busy hold sched_busy", 32'(o_sched_busy), 32'd0);
        i_eng_busy = 1'b0;
        c0 = cyc;
        runJob("busy release", 2'd0, 4, 1'b0, 1'b1, sc);
        checkOutput("busy release latency", 32'(sc - c0), 32'd2);
        settle();

        // Starvation guard: lz4 x4 then blit
        i_lz4_AB = 1'b0; i_lz4_size = 32'd5000; i_blit_bytes = 32'd1000;
        for (int k = 0; k < 4; k++) pushJob(2'd2, LZ4A_BASE, 32'd5000);
        pushJob(2'd3, BLIT_BASE, 32'd1000);
        applyStimulus(2'd2, 1'b1); applyStimulus(2'd3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            runJob("t4 grant", (k < 4) ? 2'd2 : 2'd3, 3, 1'b0, 1'b0, sc);
        end
        applyStimulus(2'd2, 1'b0); applyStimulus(2'd3, 1'b0);
        settle();

        // Watchdog expiry, then done on the expiry cycle
        pushJob(2'd0, SWR_BASE, SWR_BYTES);
        applyStimulus(2'd0, 1'b1);
        runJob("t5 timeout", 2'd0, -1, 1'b1, 1'b1, sc);
        settle();
        checkOutput("t5 idle after timeout", 32'(o_sched_busy), 32'd0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tick();
        checkOutput("t5 err cleared by reset", 32'(o_err_timeout), 32'd0);
        pushJob(2'd0, SWR_BASE, SWR_BYTES);
        applyStimulus(2'd0, 1'b1);
        runJob("t5 same cycle", 2'd0, TB_TIMEOUT, 1'b0, 1'b1, sc);
        settle();

        // Reset during WAIT, flag re-granted afterwards
        pushJob(2'd3, BLIT_BASE, 32'd1000);
        applyStimulus(2'd3, 1'b1);
        waitStart("t6 first", sc, ok);
        repeat (3) tick();
        i_reset = 1'b1;
        tick();
        checkAllZero("t6 reset");
        i_reset = 1'b0;
        rc = cyc;
        pushJob(2'd3, BLIT_BASE, 32'd1000);
        waitStart("t6 regrant", sc, ok);
        checkOutput("t6 regrant latency", 32'(sc - rc), 32'd2);
        if (ok) finishJob("t6 regrant", sc, 5, 2'd3, 1'b1, 1'b0);
        else applyStimulus(2'd3, 1'b0);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
